wb_pipe_mux_unit: RTL
=====================

// Module: wb_pipe_mux_unit
// PURPOSE
// - Parametrised write-back stage for the RV32 pipeline: selects WB data from NSRC packed sources, registers it with rd/wr_en.
// - Buffers up to 2 results (main + skid) so the regfile write port can back-pressure; valid/ready on both sides.
// - Keeps the combinational ALU 2nd-operand mux (imm vs rs2) and exports a forwarding tap for the hazard unit.
// PARAMETERS
// - XLEN   32  datapath width
// - NSRC   8   number of WB sources (alu, lu, imm, iadder, csr, pc+4, ...); SEL_W = $clog2(NSRC) (min 1)
// - RA_W   5   register-address width
// PORTS
// - clk_in               in   1           rising-edge clock
// - reset_in             in   1           synchronous, active-high reset
// - valid_in             in   1           upstream result valid
// - ready_out            out  1           buffer can accept (count<2)
// - wb_mux_sel_in        in   SEL_W       source select
// - wb_src_in            in   NSRC*XLEN   packed sources, source k at [k*XLEN +: XLEN]
// - rd_addr_in           in   RA_W        destination register
// - rf_wr_en_in          in   1           instruction writes rd
// - alu_src_in           in   1           1: imm_in, 0: rs2_in to ALU operand 2
// - imm_in, rs2_in       in   XLEN        ALU operand-2 candidates
// - alu_2nd_src_mux_out  out  XLEN        combinational operand-2 mux
// - flush_in             in   1           discard all buffered, uncommitted results
// - wb_valid_out         out  1           head entry valid to regfile
// - wb_ready_in          in   1           regfile accepts head
// - wb_data_out          out  XLEN        head data
// - wb_rd_addr_out       out  RA_W        head rd
// - wb_wr_en_out         out  1           head write enable (0 if rd==0)
// - fwd_valid_out        out  1           youngest buffered entry writes a nonzero rd
// - fwd_rd_out           out  RA_W        youngest entry rd
// - fwd_data_out         out  XLEN        youngest entry data
// - sel_err_out          out  1           sticky: accepted select >= NSRC
// BEHAVIOUR
// - Reset: count=0, both entries cleared; wb_valid_out=0, wb_data_out=0, wb_rd_addr_out=0, wb_wr_en_out=0,
//   fwd_*=0, sel_err_out=0, ready_out=1. alu_2nd_src_mux_out purely combinational (no reset value).
// - push = valid_in & ready_out; pop = wb_valid_out & wb_ready_in. Entry stores {data, rd, wr_en}.
// - Data latched = wb_src_in[sel] if sel<NSRC, else 0 and sel_err_out sets (cleared only by reset).
// - wr_en stored = rf_wr_en_in & (rd_addr_in != 0).
// - Latency: accepted result appears on wb_* the cycle after the accepting edge; no same-cycle bypass.
// - ready_out derived from registered count only; no combinational path wb_ready_in -> ready_out.
// - count transitions: push&!pop +1; pop&!push -1; push&pop (count==1) unchanged, head <- new entry.
// - count==2: ready_out=0, push impossible; pop moves skid entry to head next cycle.
// - count==0: wb_valid_out=0; wb_ready_in ignored.
// - Order strictly FIFO; head entry and its outputs stable while wb_valid_out & !wb_ready_in.
// - Forward tap: youngest entry (skid if count==2, else head); fwd_valid_out = count!=0 & that wr_en.
// - flush_in: next edge count=0, valid/fwd outputs 0; simultaneous push/pop ignored. sel_err_out unaffected.
// - Priority: reset_in > flush_in > push/pop.
// STRUCTURE
// - Shared package rv_core_pkg: XLEN, RA_W, WB source index constants (WB_ALU=0, WB_LU=1, WB_IMM=2,
//   WB_IADDER=3, WB_CSR=4, WB_PC4=5), wb_entry_t {data, rd, wr_en}.
// - One sub-module: wb_skid_buf (2-entry valid/ready buffer, parametrised on entry width); mux and
//   operand-2 mux stay inline.
// TESTING
// - Reset held 2 cycles -> all outputs 0, ready_out=1; release, no valid_in -> wb_valid_out stays 0.
// - sel=0 src0=0x0000_1234 rd=5 wr_en=1, wb_ready_in=1 -> next cycle wb_data_out=0x1234, rd=5, wr_en=1, one beat.
// - wb_ready_in=0, push 3 results A,B,C -> A,B accepted, ready_out=0 on 3rd; release -> A then B in order,
//   head held stable while stalled; fwd_* shows B when count==2.
// - count==1 with simultaneous push/pop each cycle for 10 cycles -> count stays 1, one result per cycle.
// - rd=0 wr_en=1 -> wb_wr_en_out=0, fwd_valid_out=0; sel=7 with NSRC=6 -> data 0, sel_err_out=1 sticky.
// - flush_in with count=2 plus concurrent valid_in -> next cycle wb_valid_out=0, count=0, pushed data dropped.

Source files
------------

// File: rtl/rv_core_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv_core_pkg
// Description : Shared RV32 core constants: datapath widths, write-back source
//               indices and the write-back entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_core_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    // Write-back source indices into the packed source bus
    localparam int WB_ALU    = 0;
    localparam int WB_LU     = 1;
    localparam int WB_IMM    = 2;
    localparam int WB_IADDER = 3;
    localparam int WB_CSR    = 4;
    localparam int WB_PC4    = 5;

    // Field order matches the packed entry used inside the write-back stage
    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RA_W-1:0] rd;
        logic            wr_en;
    } wb_entry_t;

endpackage : rv_core_pkg
`default_nettype wire

// File: rtl/wb_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : wb_skid_buf
// Description : Two-entry valid/ready FIFO (head + skid). Upstream ready is a
//               function of the registered occupancy only, so there is no
//               combinational path from downstream ready to upstream ready.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_skid_buf #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push_valid,
    output logic         o_push_ready,
    input  logic [W-1:0] i_push_data,
    output logic         o_pop_valid,
    input  logic         i_pop_ready,
    output logic [W-1:0] o_pop_data,
    output logic [W-1:0] o_tail_data,
    output logic         o_tail_valid
);

    localparam logic [1:0] c_CNT_EMPTY = 2'd0;
    localparam logic [1:0] c_CNT_ONE   = 2'd1;
    localparam logic [1:0] c_CNT_FULL  = 2'd2;

    logic [1:0]   r_count;
    logic [W-1:0] r_head;
    logic [W-1:0] r_skid;
    logic         w_push;
    logic         w_pop;

    assign o_push_ready = (r_count != c_CNT_FULL);
    assign o_pop_valid  = (r_count != c_CNT_EMPTY);
    assign w_push       = i_push_valid & o_push_ready;
    assign w_pop        = o_pop_valid & i_pop_ready;
    assign o_pop_data   = r_head;

    // Youngest entry: skid when full, otherwise head (zero when empty)
    assign o_tail_data  = (r_count == c_CNT_FULL) ? r_skid : r_head;
    assign o_tail_valid = o_pop_valid;

    // Occupancy and storage update; vacated slots are zeroed so idle outputs read 0
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_count <= c_CNT_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_count)
                c_CNT_EMPTY: begin
                    if (w_push) begin
                        r_head  <= i_push_data;
                        r_count <= c_CNT_ONE;
                    end
                end
                c_CNT_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= i_push_data;
                    end else if (w_push) begin
                        r_skid  <= i_push_data;
                        r_count <= c_CNT_FULL;
                    end else if (w_pop) begin
                        r_head  <= '0;
                        r_count <= c_CNT_EMPTY;
                    end
                end
                c_CNT_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_skid;
                        r_skid  <= '0;
                        r_count <= c_CNT_ONE;
                    end
                end
                default: begin
                    r_count <= c_CNT_EMPTY;
                    r_head  <= '0;
                    r_skid  <= '0;
                end
            endcase
        end
    end

endmodule : wb_skid_buf
`default_nettype wire

// File: rtl/wb_pipe_mux_unit.sv
`default_nettype none
// ============================================================================
// Module      : wb_pipe_mux_unit
// Description : RV32 write-back stage. Selects WB data from NSRC packed
//               sources, buffers up to two results for a back-pressured
//               regfile port, provides the ALU operand-2 mux and a
//               forwarding tap of the youngest buffered result.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pipe_mux_unit
    import rv_core_pkg::*;
#(
    parameter int XLEN  = rv_core_pkg::XLEN,
    parameter int NSRC  = 8,
    parameter int RA_W  = rv_core_pkg::RA_W,
    parameter int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [SEL_W-1:0]     wb_mux_sel_in,
    input  logic [NSRC*XLEN-1:0] wb_src_in,
    input  logic [RA_W-1:0]      rd_addr_in,
    input  logic                 rf_wr_en_in,
    input  logic                 alu_src_in,
    input  logic [XLEN-1:0]      imm_in,
    input  logic [XLEN-1:0]      rs2_in,
    output logic [XLEN-1:0]      alu_2nd_src_mux_out,
    input  logic                 flush_in,
    output logic                 wb_valid_out,
    input  logic                 wb_ready_in,
    output logic [XLEN-1:0]      wb_data_out,
    output logic [RA_W-1:0]      wb_rd_addr_out,
    output logic                 wb_wr_en_out,
    output logic                 fwd_valid_out,
    output logic [RA_W-1:0]      fwd_rd_out,
    output logic [XLEN-1:0]      fwd_data_out,
    output logic                 sel_err_out
);

    // Entry layout {data, rd, wr_en}, same field order as wb_entry_t
    localparam int c_ENT_W = XLEN + RA_W + 1;

    logic [XLEN-1:0]    w_sel_data;
    logic               w_sel_ok;
    logic [c_ENT_W-1:0] w_new_entry;
    logic [c_ENT_W-1:0] w_head;
    logic [c_ENT_W-1:0] w_tail;
    logic               w_tail_valid;
    logic               r_sel_err;

    // ALU operand-2 select: immediate or rs2
    assign alu_2nd_src_mux_out = alu_src_in ? imm_in : rs2_in;

    // WB source mux; an out-of-range select yields zero data and flags an error
    always_comb begin
        w_sel_data = '0;
        w_sel_ok   = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (wb_mux_sel_in == SEL_W'(k)) begin
                w_sel_data = wb_src_in[k*XLEN +: XLEN];
                w_sel_ok   = 1'b1;
            end
        end
    end

    // Writes to x0 are suppressed at capture time so every consumer sees wr_en=0
    assign w_new_entry = {w_sel_data, rd_addr_in, rf_wr_en_in & (rd_addr_in != '0)};

    wb_skid_buf #(
        .W (c_ENT_W)
    ) u_buf (
        .clk          (clk_in),
        .rst          (reset_in),
        .i_flush      (flush_in),
        .i_push_valid (valid_in),
        .o_push_ready (ready_out),
        .i_push_data  (w_new_entry),
        .o_pop_valid  (wb_valid_out),
        .i_pop_ready  (wb_ready_in),
        .o_pop_data   (w_head),
        .o_tail_data  (w_tail),
        .o_tail_valid (w_tail_valid)
    );

    assign wb_data_out    = w_head[c_ENT_W-1 -: XLEN];
    assign wb_rd_addr_out = w_head[RA_W:1];
    assign wb_wr_en_out   = w_head[0];

    assign fwd_data_out   = w_tail[c_ENT_W-1 -: XLEN];
    assign fwd_rd_out     = w_tail[RA_W:1];
    assign fwd_valid_out  = w_tail_valid & w_tail[0];

    // Sticky select-error flag, set only by an accepted (non-flushed) push
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_sel_err <= 1'b0;
        end else if (!flush_in && valid_in && ready_out && !w_sel_ok) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err_out = r_sel_err;

endmodule : wb_pipe_mux_unit
`default_nettype wire
